// File: rtl/regs_arb.sv
// rtl/regs_arb.sv - register file port arbiter between the core pipeline and a debug requester,
// with post-reset clearing, a starvation guard and read-after-write bypass.
module regs_arb #(
  parameter int W          = 32,
  parameter int STARVE_MAX = 15
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         core_ren,
  input  logic [4:0]   core_rs1,
  input  logic [4:0]   core_rs2,
  input  logic         core_wen,
  input  logic [4:0]   core_rd,
  input  logic [W-1:0] core_rd_val,
  output logic [W-1:0] core_rs1_val,
  output logic [W-1:0] core_rs2_val,
  output logic         core_stall,
  input  logic         dbg_req_valid,
  output logic         dbg_req_ready,
  input  logic         dbg_req_we,
  input  logic [4:0]   dbg_req_addr,
  input  logic [W-1:0] dbg_req_wdata,
  output logic         dbg_rsp_valid,
  output logic [W-1:0] dbg_rsp_rdata,
  output logic         rf_ren,
  output logic [4:0]   rf_rs1,
  output logic [4:0]   rf_rs2,
  output logic         rf_wen,
  output logic [4:0]   rf_rd,
  output logic [W-1:0] rf_rd_val,
  input  logic [W-1:0] rf_rs1_val,
  input  logic [W-1:0] rf_rs2_val
);

  localparam int SW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);

  typedef enum logic {S_CLEAR, S_RUN} state_t;

  state_t         state_q, state_d;
  logic [4:0]     clr_cnt_q;
  logic [SW-1:0]  starve_q;
  logic           core_rvalid_q;
  logic           rsp_pend_q;
  logic           rsp_rd_q;
  logic           byp1_q, byp2_q;
  logic [W-1:0]   byp_val_q;
  logic [W-1:0]   hold1_q, hold2_q;

  logic           starve_cyc;
  logic           core_ren_eff, core_wen_eff;
  logic           dbg_rd_gnt, dbg_wr_gnt;
  logic [W-1:0]   rs1_fix, rs2_fix;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_CLEAR;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_CLEAR: if (clr_cnt_q == 5'd31) state_d = S_RUN;
      S_RUN:   state_d = S_RUN;
      default: state_d = S_CLEAR;
    endcase
  end

  always_comb begin
    core_stall    = 1'b1;
    dbg_req_ready = 1'b0;
    rf_ren        = 1'b0;
    rf_rs1        = 5'd0;
    rf_rs2        = 5'd0;
    rf_wen        = 1'b0;
    rf_rd         = 5'd0;
    rf_rd_val     = '0;
    starve_cyc    = 1'b0;
    core_ren_eff  = 1'b0;
    core_wen_eff  = 1'b0;
    dbg_rd_gnt    = 1'b0;
    dbg_wr_gnt    = 1'b0;
    if (!rst) begin
      case (state_q)
        S_CLEAR: begin
          rf_wen = 1'b1;
          rf_rd  = clr_cnt_q;
        end
        S_RUN: begin
          // A starvation cycle steals both ports from the core for one cycle.
          starve_cyc    = dbg_req_valid && (starve_q == SW'(STARVE_MAX));
          core_ren_eff  = core_ren & ~starve_cyc;
          core_wen_eff  = core_wen & ~starve_cyc;
          dbg_rd_gnt    = dbg_req_valid & ~dbg_req_we & ~core_ren_eff;
          dbg_wr_gnt    = dbg_req_valid &  dbg_req_we & ~core_wen_eff;
          core_stall    = starve_cyc;
          dbg_req_ready = dbg_rd_gnt | dbg_wr_gnt;
          rf_ren        = core_ren_eff | dbg_rd_gnt;
          rf_rs1        = dbg_rd_gnt ? dbg_req_addr : core_rs1;
          rf_rs2        = dbg_rd_gnt ? 5'd0 : core_rs2;
          rf_wen        = (core_wen_eff && core_rd != 5'd0) ||
                          (dbg_wr_gnt && dbg_req_addr != 5'd0);
          rf_rd         = dbg_wr_gnt ? dbg_req_addr : core_rd;
          rf_rd_val     = dbg_wr_gnt ? dbg_req_wdata : core_rd_val;
        end
        default: ;
      endcase
    end
  end

  // The file returns the pre-write value on a same-edge hazard; substitute the written data.
  assign rs1_fix = byp1_q ? byp_val_q : rf_rs1_val;
  assign rs2_fix = byp2_q ? byp_val_q : rf_rs2_val;

  assign core_rs1_val  = rst ? '0 : (core_rvalid_q ? rs1_fix : hold1_q);
  assign core_rs2_val  = rst ? '0 : (core_rvalid_q ? rs2_fix : hold2_q);
  assign dbg_rsp_valid = ~rst & rsp_pend_q;
  assign dbg_rsp_rdata = (dbg_rsp_valid && rsp_rd_q) ? rs1_fix : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clr_cnt_q     <= 5'd1;
      starve_q      <= '0;
      core_rvalid_q <= 1'b0;
      rsp_pend_q    <= 1'b0;
      rsp_rd_q      <= 1'b0;
      byp1_q        <= 1'b0;
      byp2_q        <= 1'b0;
      byp_val_q     <= '0;
      hold1_q       <= '0;
      hold2_q       <= '0;
    end else begin
      if (state_q == S_CLEAR) clr_cnt_q <= clr_cnt_q + 5'd1;
      if (state_q == S_RUN && dbg_req_valid && !dbg_req_ready)
        starve_q <= starve_q + SW'(1);
      else
        starve_q <= '0;
      core_rvalid_q <= core_ren_eff;
      rsp_pend_q    <= dbg_req_ready;
      rsp_rd_q      <= dbg_rd_gnt;
      byp1_q        <= rf_ren & rf_wen & (rf_rd != 5'd0) & (rf_rd == rf_rs1);
      byp2_q        <= rf_ren & rf_wen & (rf_rd != 5'd0) & (rf_rd == rf_rs2);
      byp_val_q     <= rf_rd_val;
      if (core_rvalid_q) begin
        hold1_q <= rs1_fix;
        hold2_q <= rs2_fix;
      end
    end
  end

endmodule

// File: tb/tb_regs_arb.sv
// tb/tb_regs_arb.sv - randomized bench for regs_arb against an architectural register model.
module tb_regs_arb;

  localparam int W          = 32;
  localparam int STARVE_MAX = 15;

  logic         clk = 1'b0;
  logic         rst;
  logic         core_ren, core_wen;
  logic [4:0]   core_rs1, core_rs2, core_rd;
  logic [W-1:0] core_rd_val;
  logic [W-1:0] core_rs1_val, core_rs2_val;
  logic         core_stall;
  logic         dbg_req_valid, dbg_req_ready, dbg_req_we;
  logic [4:0]   dbg_req_addr;
  logic [W-1:0] dbg_req_wdata;
  logic         dbg_rsp_valid;
  logic [W-1:0] dbg_rsp_rdata;
  logic         rf_ren, rf_wen;
  logic [4:0]   rf_rs1, rf_rs2, rf_rd;
  logic [W-1:0] rf_rd_val;
  logic [W-1:0] rf_rs1_val, rf_rs2_val;

  always #5 clk = ~clk;

  regs_arb #(.W(W), .STARVE_MAX(STARVE_MAX)) dut (
    .clk(clk), .rst(rst),
    .core_ren(core_ren), .core_rs1(core_rs1), .core_rs2(core_rs2),
    .core_wen(core_wen), .core_rd(core_rd), .core_rd_val(core_rd_val),
    .core_rs1_val(core_rs1_val), .core_rs2_val(core_rs2_val), .core_stall(core_stall),
    .dbg_req_valid(dbg_req_valid), .dbg_req_ready(dbg_req_ready), .dbg_req_we(dbg_req_we),
    .dbg_req_addr(dbg_req_addr), .dbg_req_wdata(dbg_req_wdata),
    .dbg_rsp_valid(dbg_rsp_valid), .dbg_rsp_rdata(dbg_rsp_rdata),
    .rf_ren(rf_ren), .rf_rs1(rf_rs1), .rf_rs2(rf_rs2),
    .rf_wen(rf_wen), .rf_rd(rf_rd), .rf_rd_val(rf_rd_val),
    .rf_rs1_val(rf_rs1_val), .rf_rs2_val(rf_rs2_val)
  );

  // Register file neighbour: synchronous read returning the pre-write value, x0 protected.
  logic [W-1:0] mem [32];
  logic         scramble = 1'b0;

  always @(posedge clk) begin
    if (scramble) begin
      mem[0] <= '0;
      for (int i = 1; i < 32; i++) mem[i] <= $urandom;
    end else begin
      if (rf_ren) begin
        rf_rs1_val <= mem[rf_rs1];
        rf_rs2_val <= mem[rf_rs2];
      end
      if (rf_wen && rf_rd != 5'd0) mem[rf_rd] <= rf_rd_val;
    end
  end

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // Architectural view: a read issued in a cycle sees every write granted in that same cycle.
  logic [W-1:0] arch [32];
  int           starve;
  logic [W-1:0] exp_c1, exp_c2;
  logic         last_ready;

  task automatic model_reset();
    for (int i = 0; i < 32; i++) arch[i] = '0;
    starve = 0;
    exp_c1 = '0;
    exp_c2 = '0;
  endtask

  task automatic idle_inputs();
    core_ren = 0; core_rs1 = 0; core_rs2 = 0;
    core_wen = 0; core_rd = 0; core_rd_val = 0;
    dbg_req_valid = 0; dbg_req_we = 0; dbg_req_addr = 0; dbg_req_wdata = 0;
  endtask

  task automatic step(input logic c_ren, input logic [4:0] c_rs1, input logic [4:0] c_rs2,
                      input logic c_wen, input logic [4:0] c_rd, input logic [W-1:0] c_val,
                      input logic d_valid, input logic d_we, input logic [4:0] d_addr,
                      input logic [W-1:0] d_wdata);
    logic         stall_c, cr, cw, gnt, dw;
    logic [W-1:0] exp_rdata;
    core_ren = c_ren; core_rs1 = c_rs1; core_rs2 = c_rs2;
    core_wen = c_wen; core_rd = c_rd; core_rd_val = c_val;
    dbg_req_valid = d_valid; dbg_req_we = d_we; dbg_req_addr = d_addr; dbg_req_wdata = d_wdata;
    #1;
    stall_c = d_valid && (starve == STARVE_MAX);
    cr      = c_ren && !stall_c;
    cw      = c_wen && !stall_c;
    gnt     = d_valid && (d_we ? !cw : !cr);
    dw      = gnt && d_we;
    check("stall", core_stall, stall_c);
    check("ready", dbg_req_ready, gnt);
    check("rf_wen", rf_wen, (cw && c_rd != 0) || (dw && d_addr != 0));
    starve = (gnt || !d_valid) ? 0 : starve + 1;
    if (cw && c_rd != 0)   arch[c_rd]   = c_val;
    if (dw && d_addr != 0) arch[d_addr] = d_wdata;
    if (cr) begin
      exp_c1 = arch[c_rs1];
      exp_c2 = arch[c_rs2];
    end
    exp_rdata  = (gnt && !d_we) ? arch[d_addr] : '0;
    last_ready = gnt;
    @(posedge clk);
    @(negedge clk);
    check("core_rs1", core_rs1_val, exp_c1);
    check("core_rs2", core_rs2_val, exp_c2);
    check("rsp_valid", dbg_rsp_valid, gnt);
    if (gnt) check("rsp_rdata", dbg_rsp_rdata, exp_rdata);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_stall"}, core_stall, 1);
    check({tag, "_ready"}, dbg_req_ready, 0);
    check({tag, "_rspv"}, dbg_rsp_valid, 0);
    check({tag, "_rspd"}, dbg_rsp_rdata, 0);
    check({tag, "_rs1"}, core_rs1_val, 0);
    check({tag, "_rfwen"}, rf_wen, 0);
    check({tag, "_rfren"}, rf_ren, 0);
  endtask

  // Called on a negedge right after reset release; debug keeps requesting to prove it is refused.
  task automatic run_clear();
    idle_inputs();
    dbg_req_valid = 1;
    for (int i = 1; i <= 31; i++) begin
      #1;
      check("clr_wen", rf_wen, 1);
      check("clr_rd", rf_rd, i[4:0]);
      check("clr_val", rf_rd_val, 0);
      check("clr_stall", core_stall, 1);
      check("clr_ready", dbg_req_ready, 0);
      check("clr_rspv", dbg_rsp_valid, 0);
      @(negedge clk);
    end
    idle_inputs();
    #1;
    check("run_stall", core_stall, 0);
    check("run_wen", rf_wen, 0);
    model_reset();
  endtask

  int           wait_n;
  logic         pend, p_we;
  logic [4:0]   p_addr;
  logic [W-1:0] p_data;

  initial begin
    idle_inputs();
    rst = 1;
    dbg_req_valid = 1;
    scramble = 1;
    repeat (2) @(negedge clk);
    scramble = 0;
    #1;
    check_reset_outputs("rst");
    @(negedge clk);
    rst = 0;
    run_clear();

    // Clear really wrote zeros over the junk, and a debug read of x5 sees it.
    step(0, 0, 0, 0, 0, 0, 1, 0, 5, 0);

    // Same-edge write/read of x3 relies on the bypass; a later read sees the file contents.
    step(1, 3, 0, 1, 3, 32'hDEADBEEF, 0, 0, 0, 0);
    step(1, 3, 3, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // Debug read while core idles must not disturb the core-visible value.
    step(0, 0, 0, 1, 3, 32'h11, 0, 0, 0, 0);
    step(0, 0, 0, 1, 4, 32'h22, 0, 0, 0, 0);
    step(1, 3, 0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 1, 0, 4, 0);
    check("hold_rs1", core_rs1_val, 32'h11);

    // Starvation: core reads every cycle; the debug read wins on its 16th cycle.
    wait_n = 0;
    last_ready = 0;
    while (!last_ready && wait_n < 40) begin
      step(1, 1, 2, 0, 0, 0, 1, 0, 4, 0);
      wait_n++;
    end
    check("starve_wait", wait_n, 16);
    step(1, 1, 2, 0, 0, 0, 1, 0, 3, 0);

    // Write to x0 is acknowledged with rdata 0 and x0 stays 0.
    step(0, 0, 0, 0, 0, 0, 1, 1, 0, 32'h5);
    step(0, 0, 0, 0, 0, 0, 1, 0, 0, 0);

    // Debug write granted alongside a core read of the same register (bypass on debug data).
    step(1, 7, 0, 0, 0, 0, 1, 1, 7, 32'hCAFEF00D);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // Randomized traffic; debug holds each request until it is accepted.
    pend = 0; p_we = 0; p_addr = 0; p_data = 0;
    for (int n = 0; n < 800; n++) begin
      if (!pend && $urandom_range(0, 9) < 4) begin
        pend   = 1;
        p_we   = $urandom_range(0, 1);
        p_addr = 5'($urandom_range(0, 7));
        p_data = $urandom;
      end
      step($urandom_range(0, 3) != 0, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
           $urandom_range(0, 1), 5'($urandom_range(0, 7)), $urandom,
           pend, p_we, p_addr, p_data);
      if (last_ready) pend = 0;
    end
    idle_inputs();
    @(negedge clk);
    for (int i = 0; i < 32; i++) check("mem", mem[i], arch[i]);

    // Reset in the middle of CLEAR restarts it from x1.
    rst = 1;
    #1;
    @(negedge clk);
    rst = 0;
    repeat (9) @(negedge clk);
    #1;
    check("midclr_rd", rf_rd, 10);
    rst = 1;
    #1;
    check_reset_outputs("midclr");
    @(negedge clk);
    rst = 0;
    run_clear();

    // Reset while a debug response is pending drops that response.
    dbg_req_valid = 1; dbg_req_we = 0; dbg_req_addr = 9;
    @(posedge clk);
    #1;
    check("pend_rspv", dbg_rsp_valid, 1);
    dbg_req_valid = 0;
    rst = 1;
    #1;
    check_reset_outputs("pendrst");
    @(negedge clk);
    rst = 0;
    run_clear();
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 1, 0, 3, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
